// File: rtl/ro_puf_resp_gen_pkg.sv
// Shared constants, FSM state encoding and vote helper for the RO-PUF reader.
// Consumers: ro_edge_counter and ro_puf_resp_gen (build option PUF_MAJ3_EN).
package ro_puf_pkg;

  localparam int NUM_RO_DEF   = 16;
  localparam int CNT_W_DEF    = 16;
  localparam int SYNC_STAGES  = 2;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Two or more "A faster" votes out of three passes wins.
  function automatic logic vote_majority(input logic [1:0] votes);
    return (votes >= 2'd2);
  endfunction

endpackage

// File: rtl/ro_puf_resp_gen_if.sv
// Challenge/response handshake between the collection logic (master) and the PUF reader (slave).
interface ro_puf_resp_gen_if #(
  parameter int SEL_W = 4,
  parameter int CNT_W = ro_puf_pkg::CNT_W_DEF
);
  logic             start;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             ready;
  logic             resp_valid;
  logic             resp_bit;
  logic             tie;
  logic             err;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;

  modport master (
    output start, sel_a, sel_b,
    input  ready, resp_valid, resp_bit, tie, err, count_a, count_b
  );

  modport slave (
    input  start, sel_a, sel_b,
    output ready, resp_valid, resp_bit, tie, err, count_a, count_b
  );
endinterface

// File: rtl/ro_puf_resp_gen_edge_counter.sv
// Synchronizes one asynchronous oscillator output, detects rising edges and
// counts them in a saturating counter with clear and enable controls.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ro,
  input  logic             i_count_en,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_count;
  logic                   w_rise;

  assign w_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_count = r_count;

  // Synchronizer chain, edge-detect flop and saturating edge counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ro};
      r_prev <= r_sync[SYNC_STAGES-1];
      if (i_clear) begin
        r_count <= '0;
      end else if (i_count_en && w_rise && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_ONE;
      end else begin
        r_count <= r_count;
      end
    end
  end

endmodule

// File: rtl/ro_puf_resp_gen.sv
// RO-PUF response generator: enables two oscillators, counts their edges over a
// fixed window and returns one comparison bit. PUF_MAJ3_EN selects a 2-of-3 vote.
module ro_puf_resp_gen
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO        = NUM_RO_DEF,
  parameter int SEL_W         = 4,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  ro_puf_resp_gen_if.slave  bus,
  input  logic [NUM_RO-1:0] i_ro_out,
  output logic [NUM_RO-1:0] o_ro_enable
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]  DRAIN_LAST  = TMR_W'(DRAIN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE     = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_RO-1:0] RO_ONE      = {{(NUM_RO-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [SEL_W-1:0]  r_sel_a;
  logic [SEL_W-1:0]  r_sel_b;
  logic              r_ready;
  logic [NUM_RO-1:0] r_enable;
  logic              r_resp_valid;
  logic              r_resp_bit;
  logic              r_tie;
  logic              r_err;
  logic [CNT_W-1:0]  r_count_a;
  logic [CNT_W-1:0]  r_count_b;
`ifdef PUF_MAJ3_EN
  logic [1:0]        r_eval_idx;
  logic [1:0]        r_votes;
  logic [1:0]        w_votes_total;
`endif

  logic              w_ro_a;
  logic              w_ro_b;
  logic              w_count_en;
  logic              w_clear;
  logic [CNT_W-1:0]  w_cnt_a;
  logic [CNT_W-1:0]  w_cnt_b;
  logic              w_gt;
  logic              w_eq;
  logic [NUM_RO-1:0] w_mask_new;
`ifdef PUF_MAJ3_EN
  logic [NUM_RO-1:0] w_mask_cur;
`endif

  // The selection registers only change at accept, so the mux feeding each synchronizer is stable while counting.
  assign w_ro_a     = i_ro_out[r_sel_a];
  assign w_ro_b     = i_ro_out[r_sel_b];
  assign w_count_en = (r_state == ST_COUNT);
  assign w_clear    = (r_state == ST_IDLE) || (r_state == ST_ARM);
  assign w_gt       = (w_cnt_a > w_cnt_b);
  assign w_eq       = (w_cnt_a == w_cnt_b);
  assign w_mask_new = (RO_ONE << bus.sel_a) | (RO_ONE << bus.sel_b);
`ifdef PUF_MAJ3_EN
  assign w_mask_cur    = (RO_ONE << r_sel_a) | (RO_ONE << r_sel_b);
  assign w_votes_total = r_votes + {1'b0, w_gt};
`endif

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk        (clk),
    .rst        (rst),
    .i_ro       (w_ro_a),
    .i_count_en (w_count_en),
    .i_clear    (w_clear),
    .o_count    (w_cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk        (clk),
    .rst        (rst),
    .i_ro       (w_ro_b),
    .i_count_en (w_count_en),
    .i_clear    (w_clear),
    .o_count    (w_cnt_b)
  );

  // Evaluation sequencer with registered handshake, enable and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_sel_a      <= '0;
      r_sel_b      <= '0;
      r_ready      <= 1'b1;
      r_enable     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_bit   <= 1'b0;
      r_tie        <= 1'b0;
      r_err        <= 1'b0;
      r_count_a    <= '0;
      r_count_b    <= '0;
`ifdef PUF_MAJ3_EN
      r_eval_idx   <= 2'd0;
      r_votes      <= 2'd0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sel_a    <= bus.sel_a;
            r_sel_b    <= bus.sel_b;
            r_ready    <= 1'b0;
            r_timer    <= '0;
            r_resp_bit <= 1'b0;
            r_tie      <= 1'b0;
            r_count_a  <= '0;
            r_count_b  <= '0;
`ifdef PUF_MAJ3_EN
            r_eval_idx <= 2'd0;
            r_votes    <= 2'd0;
`endif
            if (bus.sel_a == bus.sel_b) begin
              r_err        <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_err    <= 1'b0;
              r_enable <= w_mask_new;
              r_state  <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (r_timer == SETTLE_LAST) begin
            r_timer <= '0;
            r_state <= ST_COUNT;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        ST_COUNT: begin
          if (r_timer == WINDOW_LAST) begin
            r_timer  <= '0;
            r_enable <= '0;
            r_state  <= ST_DRAIN;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        ST_DRAIN: begin
          if (r_timer == DRAIN_LAST) begin
            r_timer <= '0;
`ifdef PUF_MAJ3_EN
            r_tie   <= r_tie | w_eq;
            if (r_eval_idx == 2'd2) begin
              r_resp_bit   <= vote_majority(w_votes_total);
              r_count_a    <= w_cnt_a;
              r_count_b    <= w_cnt_b;
              r_resp_valid <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_votes    <= w_votes_total;
              r_eval_idx <= r_eval_idx + 2'd1;
              r_enable   <= w_mask_cur;
              r_state    <= ST_ARM;
            end
`else
            r_resp_bit   <= w_gt;
            r_tie        <= w_eq;
            r_count_a    <= w_cnt_a;
            r_count_b    <= w_cnt_b;
            r_resp_valid <= 1'b1;
            r_state      <= ST_DONE;
`endif
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_timer  <= '0;
          r_enable <= '0;
          r_ready  <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ro_enable    = r_enable;
  assign bus.ready      = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_bit   = r_resp_bit;
  assign bus.tie        = r_tie;
  assign bus.err        = r_err;
  assign bus.count_a    = r_count_a;
  assign bus.count_b    = r_count_b;

endmodule
